// File: rtl/timer_pkg.sv
// timer_pkg: shared state enum, BCD digit type and clamp helper for countdown_timer
package timer_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX = 4'd9;
  function automatic bcd_t clamp_digit(bcd_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction
endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// bcd_down_digit: combinational single BCD digit decrementer with borrow chain
module bcd_down_digit
  import timer_pkg::*;
(
  input  logic [3:0] i_d,
  input  logic       i_bin,
  output logic [3:0] o_q,
  output logic       o_bout
);
  always_comb begin
    o_q    = i_bin ? ((i_d == 4'd0) ? BCD_MAX : i_d - 4'd1) : i_d;
    o_bout = i_bin && (i_d == 4'd0);
  end
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: BCD countdown timer FSM, auto-reload on zero when COUNTDOWN_TIMER_AUTORELOAD_EN is defined
module countdown_timer
  import timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [4*DIGITS-1:0]   value,
  output logic                  running,
  output logic                  done
);
  state_t              r_state;
  logic [4*DIGITS-1:0] r_value;
  logic                r_done;
  logic [4*DIGITS-1:0] w_clamped;
  logic [4*DIGITS-1:0] w_dec;
  logic [DIGITS:0]     w_borrow;
  assign w_borrow[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    assign w_clamped[4*i+:4] = clamp_digit(load_value[4*i+:4]);
    bcd_down_digit u_dig (
      .i_d    (r_value[4*i+:4]),
      .i_bin  (w_borrow[i]),
      .o_q    (w_dec[4*i+:4]),
      .o_bout (w_borrow[i+1])
    );
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_value <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (load) begin
        r_value <= w_clamped;
        r_state <= IDLE;
      end else if (stop) begin
        if (r_state == RUN) r_state <= PAUSE;
      end else if (start) begin
        if ((r_state == IDLE || r_state == PAUSE) && r_value != '0) r_state <= RUN;
      end else if (tick && r_state == RUN && !w_borrow[DIGITS]) begin
        r_value <= w_dec;
        if (w_dec == '0) begin
          r_done <= 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (w_clamped != '0) r_value <= w_clamped;
          else r_state <= DONE;
`else
          r_state <= DONE;
`endif
        end
      end
    end
  end
  assign value   = r_value;
  assign running = (r_state == RUN);
  assign done    = r_done;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed plus randomized checks of countdown_timer against a decimal reference model
module tb_countdown_timer;
  logic        clk = 1'b0;
  logic        rst, tick, load, start, stop;
  logic [15:0] load_value;
  logic [15:0] value;
  logic        running, done;
  int tests = 0;
  int fails = 0;
  int m_val = 0;
  int m_mode = 0;
  bit m_done = 1'b0;
  countdown_timer #(.DIGITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .value      (value),
    .running    (running),
    .done       (done)
  );
  always #5 clk = ~clk;
  function automatic int clampv(logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      int d = int'(v[4*i+:4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction
  function automatic logic [15:0] to_bcd(int n);
    logic [15:0] b;
    for (int i = 0; i < 4; i++) begin
      b[4*i+:4] = 4'(n % 10);
      n = n / 10;
    end
    return b;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic r, input logic ld, input logic [15:0] lv,
                      input logic st, input logic sp, input logic tk);
    rst = r; load = ld; load_value = lv; start = st; stop = sp; tick = tk;
    @(posedge clk);
    if (r) begin
      m_val = 0; m_mode = 0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (ld) begin
        m_val = clampv(lv); m_mode = 0;
      end else if (sp) begin
        if (m_mode == 1) m_mode = 2;
      end else if (st) begin
        if ((m_mode == 0 || m_mode == 2) && m_val != 0) m_mode = 1;
      end else if (tk && m_mode == 1) begin
        m_val = m_val - 1;
        if (m_val == 0) begin
          m_done = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
          if (clampv(lv) != 0) m_val = clampv(lv);
          else m_mode = 3;
`else
          m_mode = 3;
`endif
        end
      end
    end
    #1;
    chk("value", 32'(value), 32'(to_bcd(m_val)));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("done", 32'(done), 32'(m_done));
  endtask
  initial begin
    rst = 1'b1; tick = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0; load_value = '0;
    step(1, 0, 16'h0000, 0, 0, 0);
    chk("reset_value", 32'(value), 32'h0);
    chk("reset_running", 32'(running), 32'h0);
    step(0, 1, 16'h0012, 0, 0, 0);
    step(0, 0, 16'h0012, 1, 0, 0);
    step(0, 0, 16'h0012, 0, 0, 1);
    chk("dec_11", 32'(value), 32'h0011);
    step(0, 0, 16'h0012, 0, 0, 1);
    chk("dec_10", 32'(value), 32'h0010);
    step(0, 0, 16'h0012, 0, 0, 1);
    chk("dec_09", 32'(value), 32'h0009);
    chk("run_high", 32'(running), 32'h1);
`ifndef COUNTDOWN_TIMER_AUTORELOAD_EN
    step(0, 1, 16'h0001, 0, 0, 0);
    step(0, 0, 16'h0001, 1, 0, 0);
    step(0, 0, 16'h0001, 0, 0, 1);
    chk("zero_value", 32'(value), 32'h0);
    chk("zero_done", 32'(done), 32'h1);
    step(0, 0, 16'h0001, 0, 0, 0);
    chk("done_pulse_end", 32'(done), 32'h0);
    step(0, 0, 16'h0001, 1, 0, 0);
    step(0, 0, 16'h0001, 0, 0, 1);
    chk("done_hold", 32'(value), 32'h0);
    chk("done_not_running", 32'(running), 32'h0);
`endif
    step(0, 1, 16'h1000, 0, 0, 0);
    step(0, 0, 16'h1000, 1, 0, 0);
    step(0, 0, 16'h1000, 0, 0, 1);
    chk("ripple", 32'(value), 32'h0999);
    step(0, 1, 16'h0005, 0, 0, 0);
    step(0, 0, 16'h0005, 1, 0, 0);
    step(0, 0, 16'h0005, 0, 1, 1);
    chk("stop_tick_value", 32'(value), 32'h0005);
    chk("stop_running", 32'(running), 32'h0);
    step(0, 0, 16'h0005, 1, 0, 0);
    step(0, 0, 16'h0005, 0, 0, 1);
    chk("resume_dec", 32'(value), 32'h0004);
    step(0, 1, 16'h00AF, 0, 0, 0);
    chk("clamp", 32'(value), 32'h0099);
    step(0, 1, 16'h00AF, 1, 0, 0);
    chk("load_over_start", 32'(running), 32'h0);
    step(0, 1, 16'h0001, 0, 0, 0);
    step(0, 0, 16'h0001, 1, 0, 0);
    step(1, 0, 16'h0001, 0, 0, 1);
    chk("rst_kills_done", 32'(done), 32'h0);
    chk("rst_value", 32'(value), 32'h0);
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    step(0, 1, 16'h0002, 0, 0, 0);
    step(0, 0, 16'h0002, 1, 0, 0);
    step(0, 0, 16'h0002, 0, 0, 1);
    step(0, 0, 16'h0002, 0, 0, 1);
    chk("ar_done", 32'(done), 32'h1);
    chk("ar_value", 32'(value), 32'h0002);
    chk("ar_running", 32'(running), 32'h1);
    step(0, 0, 16'h0002, 0, 0, 1);
    step(1, 0, 16'h0002, 0, 0, 0);
    chk("ar_rst_value", 32'(value), 32'h0);
    chk("ar_rst_running", 32'(running), 32'h0);
    chk("ar_rst_done", 32'(done), 32'h0);
`endif
    for (int n = 0; n < 600; n++) begin
      logic [15:0] lv;
      lv = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h0025));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 29) == 0, lv,
           $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of BCD digits (range 1..8).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port tick, input, 1 bit: one-cycle count-enable pulse, typically the overflow output of the prescaler counter.
REQ-005 The block SHALL have port load, input, 1 bit: load load_value into the count.
REQ-006 The block SHALL have port load_value, input, 4*DIGITS bits: BCD start value, digit 0 in bits [3:0].
REQ-007 The block SHALL have port start, input, 1 bit: start or resume counting.
REQ-008 The block SHALL have port stop, input, 1 bit: pause counting.
REQ-009 The block SHALL have port value, output, 4*DIGITS bits: current BCD count, registered.
REQ-010 The block SHALL have port running, output, 1 bit: high while the state is RUN.
REQ-011 The block SHALL have port done, output, 1 bit: registered one-cycle pulse when the count reaches zero.

Function
REQ-012 The block SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-013 Command priority SHALL be load > stop > start > tick, and only the highest-priority active command SHALL take effect in a cycle.
REQ-014 load in any state SHALL set value to load_value, clamping each digit above 9 to 9, and SHALL move the state to IDLE on the next edge.
REQ-015 start in IDLE or PAUSE SHALL move the state to RUN when value is nonzero; when value is zero, start SHALL be ignored.
REQ-016 stop in RUN SHALL move the state to PAUSE, and a tick in the same cycle SHALL be discarded.
REQ-017 In RUN, each tick SHALL decrement value by 1 in BCD, with the result visible one cycle after the tick.
REQ-018 A digit at 0 SHALL wrap to 9 and borrow from the next digit; borrows SHALL ripple combinationally within one cycle.
REQ-019 In IDLE, PAUSE and DONE, tick SHALL be ignored and value SHALL hold.
REQ-020 A tick in RUN that makes value zero SHALL move the state to DONE and assert done for exactly one cycle, coincident with value becoming zero.
REQ-021 In DONE, value SHALL hold at zero and start SHALL be ignored; only load or rst SHALL leave DONE.
REQ-022 running SHALL be decoded from the state register and SHALL rise on the cycle after the accepted start.
REQ-023 Ticks arriving on consecutive cycles SHALL each decrement value, with no ticks lost.

Reset
REQ-024 While rst is high, the block SHALL set value to 0, the state to IDLE, done to 0 and running to 0.
REQ-025 rst SHALL override all commands, including reset asserted during RUN or in the cycle done would pulse, in which case done SHALL stay 0.

Configuration
REQ-026 When COUNTDOWN_TIMER_AUTORELOAD_EN is defined, reaching zero in RUN SHALL pulse done, reload value from load_value (clamped) on the same edge, and keep the state in RUN.
REQ-027 When COUNTDOWN_TIMER_AUTORELOAD_EN is defined and the clamped load_value is zero, reaching zero SHALL enter DONE as in REQ-020.
REQ-028 When COUNTDOWN_TIMER_AUTORELOAD_EN is not defined, the block SHALL follow REQ-020 and REQ-021, and no reload logic SHALL be present.

Structure
REQ-029 The shared package timer_pkg SHALL hold the state enum (IDLE, RUN, PAUSE, DONE), the BCD digit typedef (4 bits) and the constant BCD_MAX = 9.
REQ-030 The block SHALL contain one sub-module, bcd_down_digit, instantiated DIGITS times: a combinational single-digit decrementer with borrow-in, next-digit output and borrow-out; all registers SHALL stay in countdown_timer.

Verification
REQ-031 The bench SHALL cover: rst, then load with load_value=0x0012, start, 3 ticks -> value 0x0011, 0x0010, 0x0009; running=1.
REQ-032 The bench SHALL cover: load 0x0001, start, 1 tick -> value=0x0000, done high for 1 cycle, state DONE; further start and ticks leave value=0x0000.
REQ-033 The bench SHALL cover: load 0x1000, start, tick -> value=0x0999 (full borrow ripple).
REQ-034 The bench SHALL cover: RUN at 0x0005, stop and tick in the same cycle -> value=0x0005, running=0; then start, tick -> 0x0004.
REQ-035 The bench SHALL cover: load_value=0x00AF with load -> value=0x0099; start and load in the same cycle -> state IDLE.
REQ-036 The bench SHALL cover, with COUNTDOWN_TIMER_AUTORELOAD_EN defined: load 0x0002, start, 2 ticks -> done pulse, value=0x0002, running=1; rst mid-run -> value=0, running=0, done=0.
